// File: rtl/sram_like_arbiter_pkg.sv
// Shared definitions for the sram-like arbiter: requester IDs, size codes,
// request field widths and the address-phase lock states.
package sram_like_arbiter_pkg;

  // Owner IDs stored in the issue-order FIFO.
  localparam logic REQ_ID_INST = 1'b0;
  localparam logic REQ_ID_DATA = 1'b1;

  // Request field widths.
  localparam int SIZE_BITS  = 2;
  localparam int WSTRB_BITS = 4;

  // Transfer size encodings.
  localparam logic [SIZE_BITS-1:0] SIZE_B = 2'd0;
  localparam logic [SIZE_BITS-1:0] SIZE_H = 2'd1;
  localparam logic [SIZE_BITS-1:0] SIZE_W = 2'd2;

  // Address-phase lock: HELD while a granted request waits for m_addr_ok.
  typedef enum logic {
    LOCK_IDLE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_e;

endpackage

// File: rtl/sram_like_arbiter_req_id_fifo.sv
// Issue-order FIFO of 1-bit requester IDs. Push and pop may occur in the
// same cycle; pointers wrap modulo DEPTH, so DEPTH need not fill a binary range.
module req_id_fifo #(
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             push_id,
  input  logic             pop,
  output logic             head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // ID storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end

  // Pointers and occupancy; simultaneous push/pop leaves count unchanged.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like memory port between an instruction-fetch requester
// and a data requester. Data has priority, inst is forced after STARVE_LIMIT
// consecutive data grants. Returns are routed in issue order.
//
// Handshake: a requester holds req and its fields stable from assertion until
// the cycle its addr_ok is high; that cycle is the acceptance. data_ok is a
// single-cycle pulse qualifying the broadcast rdata.
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  i_req,
  input  logic                  i_wr,
  input  logic [SIZE_BITS-1:0]  i_size,
  input  logic [WSTRB_BITS-1:0] i_wstrb,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic [DATA_W-1:0]     i_wdata,
  output logic                  i_addr_ok,
  output logic                  i_data_ok,
  output logic [DATA_W-1:0]     i_rdata,
  input  logic                  d_req,
  input  logic                  d_wr,
  input  logic [SIZE_BITS-1:0]  d_size,
  input  logic [WSTRB_BITS-1:0] d_wstrb,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic                  d_addr_ok,
  output logic                  d_data_ok,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  m_req,
  output logic                  m_wr,
  output logic [SIZE_BITS-1:0]  m_size,
  output logic [WSTRB_BITS-1:0] m_wstrb,
  output logic [ADDR_W-1:0]     m_addr,
  output logic [DATA_W-1:0]     m_wdata,
  input  logic                  m_addr_ok,
  input  logic                  m_data_ok,
  input  logic [DATA_W-1:0]     m_rdata,
  output logic                  busy,
  output logic                  err
);

  localparam int CNT_W    = $clog2(MAX_OUTSTANDING + 1);
  localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);

  lock_state_e          lock_state, lock_next;
  logic                 lock_owner, owner_next;
  logic [STREAK_W-1:0]  streak;
  logic                 win_valid;
  logic                 win_id;
  logic                 accept;
  logic                 pop;
  logic                 head;
  logic [CNT_W-1:0]     count;
  logic                 full;
  logic                 empty;

  // Winner selection: a held lock pins the owner, else data unless inst starves.
  always_comb begin
    win_valid = 1'b0;
    win_id    = REQ_ID_INST;
    if (lock_state == LOCK_HELD) begin
      win_valid = 1'b1;
      win_id    = lock_owner;
    end else if (d_req && !(i_req && streak >= STREAK_W'(STARVE_LIMIT))) begin
      win_valid = 1'b1;
      win_id    = REQ_ID_DATA;
    end else if (i_req) begin
      win_valid = 1'b1;
      win_id    = REQ_ID_INST;
    end
  end

  // Issue path; resetn gating keeps outputs quiet while reset is asserted.
  always_comb begin
    m_req   = resetn && win_valid && !full;
    m_wr    = 1'b0;
    m_size  = '0;
    m_wstrb = '0;
    m_addr  = '0;
    m_wdata = '0;
    if (m_req) begin
      m_wr    = (win_id == REQ_ID_DATA) ? d_wr    : i_wr;
      m_size  = (win_id == REQ_ID_DATA) ? d_size  : i_size;
      m_wstrb = (win_id == REQ_ID_DATA) ? d_wstrb : i_wstrb;
      m_addr  = (win_id == REQ_ID_DATA) ? d_addr  : i_addr;
      m_wdata = (win_id == REQ_ID_DATA) ? d_wdata : i_wdata;
    end
  end

  assign accept    = m_req && m_addr_ok;
  assign i_addr_ok = accept && (win_id == REQ_ID_INST);
  assign d_addr_ok = accept && (win_id == REQ_ID_DATA);

  // Return path: the FIFO head names the requester this return belongs to.
  assign pop       = resetn && m_data_ok && !empty;
  assign i_data_ok = pop && (head == REQ_ID_INST);
  assign d_data_ok = pop && (head == REQ_ID_DATA);
  assign i_rdata   = m_rdata;
  assign d_rdata   = m_rdata;
  assign busy      = !empty || m_req;

  req_id_fifo #(.DEPTH(MAX_OUTSTANDING)) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push    (accept),
    .push_id (win_id),
    .pop     (pop),
    .head    (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // Lock next state: hold the owner while its request is stalled.
  always_comb begin
    lock_next  = LOCK_IDLE;
    owner_next = lock_owner;
    if (m_req && !m_addr_ok) begin
      lock_next  = LOCK_HELD;
      owner_next = win_id;
    end
  end

  // Lock state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_state <= LOCK_IDLE;
      lock_owner <= REQ_ID_INST;
    end else begin
      lock_state <= lock_next;
      lock_owner <= owner_next;
    end
  end

  // Data-grant streak while inst waits; saturates at STARVE_LIMIT.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      streak <= '0;
    end else if (!i_req) begin
      streak <= '0;
    end else if (accept && win_id == REQ_ID_INST) begin
      streak <= '0;
    end else if (accept && streak < STREAK_W'(STARVE_LIMIT)) begin
      streak <= streak + 1'b1;
    end
  end

  // Sticky error: a return arrived with nothing outstanding.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                begin err <= 1'b0; end
    else if (m_data_ok && empty) begin err <= 1'b1; end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: inputs change on the falling edge,
// outputs are sampled 1 ns later, registers update on the rising edge.
module tb_sram_like_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk;
  logic              resetn;
  logic              i_req, i_wr, d_req, d_wr;
  logic [1:0]        i_size, d_size, m_size;
  logic [3:0]        i_wstrb, d_wstrb, m_wstrb;
  logic [ADDR_W-1:0] i_addr, d_addr, m_addr;
  logic [DATA_W-1:0] i_wdata, d_wdata, m_wdata;
  logic              i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
  logic [DATA_W-1:0] i_rdata, d_rdata, m_rdata;
  logic              m_req, m_wr, m_addr_ok, m_data_ok;
  logic              busy, err;

  int vectors;
  int miscompares;
  logic [0:0] exp_q[$];
  logic [0:0] exp_owner;
  logic       pat [10];

  sram_like_arbiter dut (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_wstrb(i_wstrb),
    .i_addr(i_addr), .i_wdata(i_wdata),
    .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_wstrb(d_wstrb),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .busy(busy), .err(err)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic drive_idle();
    i_req = 0; i_wr = 0; i_size = 2'd2; i_wstrb = 4'hF; i_addr = '0; i_wdata = '0;
    d_req = 0; d_wr = 0; d_size = 2'd2; d_wstrb = 4'hF; d_addr = '0; d_wdata = '0;
    m_addr_ok = 0; m_data_ok = 0; m_rdata = '0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic sample();
    #1;
  endtask

  // Scoreboard: pops the expected owner for a return and checks routing.
  task automatic check_return(input string tag);
    if (exp_q.size() == 0) begin
      check({tag, "_q_empty"}, 64'd1, 64'd0);
    end else begin
      exp_owner = exp_q.pop_front();
      check({tag, "_d_data_ok"}, 64'(d_data_ok), 64'(exp_owner));
      check({tag, "_i_data_ok"}, 64'(i_data_ok), 64'(!exp_owner));
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    pat = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    drive_idle();
    resetn = 0;
    repeat (2) next_cycle();
    sample();
    check("rst_m_req", 64'(m_req), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_data_ok", 64'({i_data_ok, d_data_ok}), 64'd0);
    next_cycle();
    resetn = 1;

    // Simultaneous single requests: data first, then inst
    next_cycle();
    i_req = 1; i_addr = 32'hBFC00000; d_req = 1; d_addr = 32'h80000000; m_addr_ok = 1;
    sample();
    check("sim_d_addr_ok", 64'(d_addr_ok), 64'd1);
    check("sim_i_addr_ok0", 64'(i_addr_ok), 64'd0);
    check("sim_m_addr_d", 64'(m_addr), 64'h80000000);
    next_cycle();
    d_req = 0; m_data_ok = 1; m_rdata = 32'hDDDD0000;
    sample();
    check("sim_i_addr_ok", 64'(i_addr_ok), 64'd1);
    check("sim_m_addr_i", 64'(m_addr), 64'hBFC00000);
    check("sim_d_data_ok", 64'(d_data_ok), 64'd1);
    check("sim_i_data_ok0", 64'(i_data_ok), 64'd0);
    check("sim_d_rdata", 64'(d_rdata), 64'hDDDD0000);
    next_cycle();
    i_req = 0; m_addr_ok = 0; m_rdata = 32'h11110000;
    sample();
    check("sim_i_data_ok", 64'(i_data_ok), 64'd1);
    check("sim_d_data_ok0", 64'(d_data_ok), 64'd0);
    check("sim_i_rdata", 64'(i_rdata), 64'h11110000);
    check("sim_busy_last", 64'(busy), 64'd1);
    next_cycle();
    drive_idle();
    sample();
    check("sim_busy_done", 64'(busy), 64'd0);

    // Lock under backpressure: inst stalled 3 cycles, data arrives in cycle 2
    next_cycle();
    i_req = 1; i_addr = 32'hBFC00000;
    sample();
    check("lock_m_req", 64'(m_req), 64'd1);
    check("lock_m_addr0", 64'(m_addr), 64'hBFC00000);
    next_cycle();
    d_req = 1; d_addr = 32'h80001000;
    sample();
    check("lock_m_addr1", 64'(m_addr), 64'hBFC00000);
    check("lock_d_addr_ok1", 64'(d_addr_ok), 64'd0);
    next_cycle();
    sample();
    check("lock_m_addr2", 64'(m_addr), 64'hBFC00000);
    next_cycle();
    m_addr_ok = 1;
    sample();
    check("lock_i_addr_ok", 64'(i_addr_ok), 64'd1);
    check("lock_d_addr_ok3", 64'(d_addr_ok), 64'd0);
    check("lock_m_addr3", 64'(m_addr), 64'hBFC00000);
    next_cycle();
    i_req = 0;
    sample();
    check("lock_d_after", 64'(d_addr_ok), 64'd1);
    check("lock_m_addr_d", 64'(m_addr), 64'h80001000);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    next_cycle();
    d_req = 0; m_addr_ok = 0; m_data_ok = 1;
    sample();
    check_return("lock_ret0");
    next_cycle();
    sample();
    check_return("lock_ret1");
    next_cycle();
    drive_idle();
    sample();
    check("lock_busy_done", 64'(busy), 64'd0);

    // Outstanding limit: third read waits until a return, with no bypass
    next_cycle();
    d_req = 1; d_addr = 32'h100; m_addr_ok = 1;
    sample();
    check("lim_acc0", 64'(d_addr_ok), 64'd1);
    next_cycle();
    d_addr = 32'h104;
    sample();
    check("lim_acc1", 64'(d_addr_ok), 64'd1);
    next_cycle();
    d_addr = 32'h108;
    sample();
    check("lim_full_m_req", 64'(m_req), 64'd0);
    check("lim_full_addr_ok", 64'(d_addr_ok), 64'd0);
    next_cycle();
    sample();
    check("lim_full_m_req2", 64'(m_req), 64'd0);
    next_cycle();
    m_data_ok = 1; m_rdata = 32'hA0;
    sample();
    check("lim_ret0", 64'(d_data_ok), 64'd1);
    check("lim_no_bypass", 64'(m_req), 64'd0);
    next_cycle();
    m_data_ok = 0;
    sample();
    check("lim_third_issue", 64'(d_addr_ok), 64'd1);
    check("lim_third_addr", 64'(m_addr), 64'h108);
    next_cycle();
    d_req = 0; m_data_ok = 1;
    sample();
    check("lim_ret1", 64'(d_data_ok), 64'd1);
    next_cycle();
    sample();
    check("lim_ret2", 64'(d_data_ok), 64'd1);
    next_cycle();
    drive_idle();
    sample();
    check("lim_busy_done", 64'(busy), 64'd0);

    // Starvation: D,D,D,D,I,D,D,D,D,I with one return per cycle after the first
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      i_req = 1; d_req = 1; m_addr_ok = 1;
      i_addr = 32'hBFC00000 + 32'(k * 4); d_addr = 32'h80000000 + 32'(k * 4);
      m_data_ok = (k > 0); m_rdata = 32'(k);
      sample();
      check($sformatf("starve_d_grant%0d", k), 64'(d_addr_ok), 64'(pat[k]));
      check($sformatf("starve_i_grant%0d", k), 64'(i_addr_ok), 64'(!pat[k]));
      if (k > 0) check_return($sformatf("starve_ret%0d", k));
      exp_q.push_back(pat[k]);
    end
    next_cycle();
    i_req = 0; d_req = 0; m_addr_ok = 0; m_data_ok = 1;
    sample();
    check_return("starve_ret_last");
    next_cycle();
    drive_idle();
    sample();
    check("starve_busy_done", 64'(busy), 64'd0);

    // Same-cycle push and pop, then a full FIFO draining in order
    next_cycle();
    i_req = 1; i_addr = 32'hA000; m_addr_ok = 1;
    sample();
    check("pp_acc_i", 64'(i_addr_ok), 64'd1);
    exp_q.push_back(1'b0);
    next_cycle();
    i_req = 0; d_req = 1; d_addr = 32'hB000; m_data_ok = 1;
    sample();
    check("pp_acc_d", 64'(d_addr_ok), 64'd1);
    check_return("pp_ret0");
    exp_q.push_back(1'b1);
    next_cycle();
    d_req = 0; i_req = 1; i_addr = 32'hC000; m_data_ok = 0;
    sample();
    check("pp_acc_i2", 64'(i_addr_ok), 64'd1);
    exp_q.push_back(1'b0);
    next_cycle();
    i_req = 0; d_req = 1; d_addr = 32'hD000; m_data_ok = 1;
    sample();
    check("pp_full_blocks", 64'(d_addr_ok), 64'd0);
    check_return("pp_ret1");
    next_cycle();
    sample();
    check("pp_acc_d2", 64'(d_addr_ok), 64'd1);
    check_return("pp_ret2");
    exp_q.push_back(1'b1);
    next_cycle();
    d_req = 0;
    sample();
    check_return("pp_ret3");
    next_cycle();
    drive_idle();
    sample();
    check("pp_busy_done", 64'(busy), 64'd0);

    // Spurious return sets the sticky error
    next_cycle();
    m_data_ok = 1;
    sample();
    check("err_no_data_ok", 64'({i_data_ok, d_data_ok}), 64'd0);
    next_cycle();
    m_data_ok = 0;
    sample();
    check("err_set", 64'(err), 64'd1);
    next_cycle();
    sample();
    check("err_sticky", 64'(err), 64'd1);

    // Asynchronous reset in the middle of a locked transaction
    next_cycle();
    d_req = 1; d_addr = 32'h200; m_addr_ok = 1;
    sample();
    check("rr_acc", 64'(d_addr_ok), 64'd1);
    next_cycle();
    d_addr = 32'h204; m_addr_ok = 0;
    sample();
    check("rr_locked_req", 64'(m_req), 64'd1);
    next_cycle();
    m_data_ok = 1; m_rdata = 32'h0;
    sample();
    check("rr_ret_before", 64'(d_data_ok), 64'd1);
    #2 resetn = 0;
    #1;
    check("rr_m_req", 64'(m_req), 64'd0);
    check("rr_data_ok", 64'({i_data_ok, d_data_ok}), 64'd0);
    check("rr_busy", 64'(busy), 64'd0);
    check("rr_err", 64'(err), 64'd0);
    check("rr_m_addr", 64'(m_addr), 64'd0);
    next_cycle();
    drive_idle();
    resetn = 1;
    sample();
    check("rr_busy_after", 64'(busy), 64'd0);
    next_cycle();
    d_req = 1; d_addr = 32'h300; m_addr_ok = 1;
    sample();
    check("rr_new_addr", 64'(m_addr), 64'h300);
    check("rr_new_ok", 64'(d_addr_ok), 64'd1);
    next_cycle();
    drive_idle();

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
